puf_resp_collector: RTL and testbench
=====================================

# puf_resp_collector

- Sequencer downstream of the single-bit PUF cell: drives its challenge, enable and clear inputs, and consumes its `resp`/`finish` outputs.
- On a `start` request it evaluates `N_BITS` successive challenges, derived from a seed by an 8-bit LFSR, and assembles the bits into one response word.
- The word is delivered over a valid/ready handshake to the host/readout logic.

## Interface
- `N_BITS`, default 8: response word width, legal 1..64.
- `SETTLE_CYC`, default 4: cycles the PUF cell is held cleared before each evaluation, legal ≥1.
- `TIMEOUT_CYC`, default 1024: RUN-state watchdog limit; used only with `PUF_TIMEOUT_EN`.
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request pulse; accepted only in IDLE.
- `seed`  in  8  base challenge, sampled when `start` is accepted.
- `busy`  out  1  high in every state except IDLE.
- `puf_chall`  out  8  challenge to PUF cell.
- `puf_en`  out  1  PUF cell ring-oscillator enable.
- `puf_rst`  out  1  PUF cell counter/arbiter clear.
- `puf_resp`  in  1  PUF cell response bit.
- `puf_finish`  in  1  PUF cell race-complete flag.
- `resp_word`  out  N_BITS  assembled response; bit k = k-th evaluation.
- `resp_valid`  out  1  response available.
- `resp_ready`  in  1  consumer accepts response.
- `resp_err`  out  1  watchdog abort flag; constant 0 without `PUF_TIMEOUT_EN`.

## Operation
- **States:** IDLE, CLEAR, RUN, DONE.
- **Reset values:** state IDLE, `busy`=0, `puf_en`=0, `puf_rst`=1, `puf_chall`=0, `resp_word`=0, `resp_valid`=0, `resp_err`=0, bit index k=0.
- **Output decode:** `puf_en`=1 only in RUN. `puf_rst`=0 only in RUN, 1 elsewhere. All outputs are registered.
- **IDLE:**
  - `start`=1 → CLEAR.
  - `puf_chall` ← (`seed`==0 ? 8'h01 : `seed`); k ← 0; `resp_word` ← 0; `resp_err` ← 0; settle counter ← 0.
- **CLEAR:**
  - Count SETTLE_CYC cycles, then → RUN.
  - `puf_finish` is ignored in this state.
- **RUN:**
  - Wait for `puf_finish`=1.
  - On that edge: `resp_word[k]` ← `puf_resp`.
  - If k==N_BITS-1 → DONE.
  - Otherwise k ← k+1, `puf_chall` ← LFSR step, settle counter ← 0, → CLEAR.
- **LFSR step (Galois, taps 0xB8):** next = {1'b0, c[7:1]} ^ (c[0] ? 8'hB8 : 8'h00). Nonzero input never produces zero.
- **DONE:**
  - `resp_valid`=1.
  - `resp_ready`=1 → IDLE; `resp_valid` drops on the next cycle.
- **Stability:** `resp_word` and `resp_err` are held until the next accepted `start`.
- **Ignored inputs:**
  - `start` outside IDLE, including DONE while in the same cycle as `resp_ready`.
  - `resp_ready` outside DONE.
- **Reset mid-operation:** `rst` has priority over all events. The next state is IDLE with all reset values; a partial word is discarded.

## Timing
- `start` sampled at edge E0 → `busy`=1 and CLEAR from E0.
- `puf_rst` stays high for SETTLE_CYC cycles; `puf_en` rises at edge E0+SETTLE_CYC.
- **Per-bit cost:** SETTLE_CYC + W cycles, where W = RUN cycles up to and including the cycle `puf_finish` is sampled high (W≥1).
- Last `puf_finish` sampled at edge Ef → `resp_valid`=1 and `resp_word` complete from Ef.
- `puf_chall` changes only on the edge leaving RUN or IDLE, so it is stable for the whole CLEAR+RUN window.
- **Minimum total:** N_BITS·(SETTLE_CYC+1) cycles from `start` to `resp_valid`.

## Configuration
- `PUF_TIMEOUT_EN` defined:
  - RUN watchdog counts RUN cycles per bit. Reaching TIMEOUT_CYC without `puf_finish` → `resp_err` ← 1, → DONE; unwritten bits remain 0.
  - `puf_finish` in the same cycle as the watchdog limit counts as a normal finish; no error.
- `PUF_TIMEOUT_EN` undefined:
  - No watchdog; RUN waits indefinitely; `resp_err` tied 0.

## Test plan
- **Reset:** assert `rst` 2 cycles → all outputs at reset values; `puf_rst`=1, `busy`=0.
- **Nominal** (N_BITS=4, SETTLE_CYC=2, `seed`=8'h01; cell model returns 1,0,1,1 after 3 RUN cycles each) → challenges 01,B8,5C,2E in order; `resp_word`=4'b1101; `resp_valid` 20 cycles after `start`.
- **Zero seed:** `seed`=8'h00 → first `puf_chall`=8'h01, second 8'hB8.
- **Backpressure:** hold `resp_ready`=0 for 10 cycles after `resp_valid`; pulse `start` meanwhile → `resp_word`/`resp_valid` stable, `start` ignored; `resp_ready`=1 → IDLE next cycle.
- **Reset mid-RUN:** assert `rst` during bit 2 → IDLE next cycle, `resp_word`=0; a fresh `start` completes normally.
- **Timeout** (`PUF_TIMEOUT_EN`, TIMEOUT_CYC=16): `puf_finish` never asserted on bit 1 → `resp_err`=1 and `resp_valid`=1 after 16 RUN cycles; `resp_word`[3:1]=0.

Source files
------------

// File: rtl/puf_resp_collector.sv
// rtl/puf_resp_collector.sv - PUF response collector: sequences N_BITS challenge evaluations into one word
//
// Walks a single-bit PUF cell through N_BITS evaluations. Challenges come
// from an 8-bit Galois LFSR seeded at start. The assembled word is handed to
// the host over a valid/ready handshake.
//
// Optional feature macro: PUF_TIMEOUT_EN (RUN-state watchdog, sets resp_err)
//
// Parameters:
//   N_BITS      response word width (1..64)
//   SETTLE_CYC  cycles the cell is held cleared before each evaluation (>=1)
//   TIMEOUT_CYC RUN cycles allowed per bit before abort (PUF_TIMEOUT_EN only)
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, seed       request pulse and base challenge (sampled in IDLE)
//   busy              high whenever not IDLE
//   puf_chall         challenge to the PUF cell
//   puf_en, puf_rst   cell enable (RUN only) and clear (all but RUN)
//   puf_resp          cell response bit
//   puf_finish        cell race-complete flag
//   resp_word         assembled response, bit k = k-th evaluation
//   resp_valid        response available
//   resp_ready        consumer accepts response
//   resp_err          watchdog abort flag (0 without PUF_TIMEOUT_EN)

module puf_resp_collector #(
    parameter int N_BITS      = 8,
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        seed,
    output logic              busy,
    output logic [7:0]        puf_chall,
    output logic              puf_en,
    output logic              puf_rst,
    input  logic              puf_resp,
    input  logic              puf_finish,
    output logic [N_BITS-1:0] resp_word,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int K_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int S_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(N_BITS - 1);
    localparam logic [S_W-1:0] S_LAST = S_W'(SETTLE_CYC - 1);

`ifdef PUF_TIMEOUT_EN
    localparam int T_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [T_W-1:0] T_LAST = T_W'(TIMEOUT_CYC - 1);
    logic [T_W-1:0] wd_cnt;
`endif

    state_t         state;
    logic [K_W-1:0] k;
    logic [S_W-1:0] settle_cnt;

    // Galois LFSR, taps 0xB8; a nonzero challenge never maps to zero.
    function automatic logic [7:0] lfsr_step(input logic [7:0] c);
        return {1'b0, c[7:1]} ^ (c[0] ? 8'hB8 : 8'h00);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            puf_en     <= 1'b0;
            puf_rst    <= 1'b1;
            puf_chall  <= 8'h00;
            resp_word  <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            k          <= '0;
            settle_cnt <= '0;
`ifdef PUF_TIMEOUT_EN
            wd_cnt     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= CLEAR;
                        busy       <= 1'b1;
                        // A zero seed would lock the LFSR at zero.
                        puf_chall  <= (seed == 8'h00) ? 8'h01 : seed;
                        k          <= '0;
                        resp_word  <= '0;
                        resp_err   <= 1'b0;
                        settle_cnt <= '0;
                    end
                end

                CLEAR: begin
                    // puf_finish is deliberately not looked at while clearing.
                    if (settle_cnt == S_LAST) begin
                        state   <= RUN;
                        puf_en  <= 1'b1;
                        puf_rst <= 1'b0;
`ifdef PUF_TIMEOUT_EN
                        wd_cnt  <= '0;
`endif
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end

                RUN: begin
                    // A finish in the watchdog's last cycle wins over the abort.
                    if (puf_finish) begin
                        resp_word[k] <= puf_resp;
                        puf_en       <= 1'b0;
                        puf_rst      <= 1'b1;
                        if (k == K_LAST) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                        end else begin
                            k          <= k + 1'b1;
                            puf_chall  <= lfsr_step(puf_chall);
                            settle_cnt <= '0;
                            state      <= CLEAR;
                        end
`ifdef PUF_TIMEOUT_EN
                    end else if (wd_cnt == T_LAST) begin
                        // Abort: remaining bits stay 0 from the IDLE clear.
                        resp_err   <= 1'b1;
                        resp_valid <= 1'b1;
                        puf_en     <= 1'b0;
                        puf_rst    <= 1'b1;
                        state      <= DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
`endif
                    end
                end

                DONE: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        resp_valid <= 1'b0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_resp_collector.sv
// tb/tb_puf_resp_collector.sv - self-checking bench for puf_resp_collector

module tb_puf_resp_collector;

    localparam int NB = 4;
    localparam int SC = 2;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    seed = 8'h00;
    logic          busy;
    logic [7:0]    puf_chall;
    logic          puf_en;
    logic          puf_rst;
    logic          puf_resp = 1'b0;
    logic          puf_finish = 1'b0;
    logic [NB-1:0] resp_word;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic          resp_err;

    puf_resp_collector #(
        .N_BITS     (NB),
        .SETTLE_CYC (SC),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .seed      (seed),
        .busy      (busy),
        .puf_chall (puf_chall),
        .puf_en    (puf_en),
        .puf_rst   (puf_rst),
        .puf_resp  (puf_resp),
        .puf_finish(puf_finish),
        .resp_word (resp_word),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_err  (resp_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // PUF cell model: finishes on the w_cfg-th RUN cycle of each bit with
    // response r_cfg; never finishes on bit hang_bit.
    int         w_cfg[NB];
    bit         r_cfg[NB];
    int         hang_bit = -1;
    int         cur_bit  = 0;
    int         run_cnt  = 0;
    logic [7:0] chall_obs[$];

    always @(negedge clk) begin
        if (puf_en === 1'b1) begin
            if (run_cnt == 0) chall_obs.push_back(puf_chall);
            run_cnt++;
            puf_finish = 1'b0;
            if (cur_bit != hang_bit && cur_bit < NB && run_cnt == w_cfg[cur_bit]) begin
                puf_finish = 1'b1;
                puf_resp   = r_cfg[cur_bit];
            end
        end else begin
            if (puf_finish) cur_bit++;
            run_cnt    = 0;
            puf_finish = 1'b0;
            puf_resp   = 1'($urandom);
        end
    end

    function automatic logic [7:0] lfsr_ref(input logic [7:0] c);
        return (c >> 1) ^ (((c % 2) == 1) ? 8'hB8 : 8'h00);
    endfunction

    task automatic randomize_cell();
        for (int i = 0; i < NB; i++) begin
            w_cfg[i] = $urandom_range(1, 6);
            r_cfg[i] = 1'($urandom);
        end
    endtask

    // One full transaction, with the expected results worked out up front.
    task automatic do_txn(input logic [7:0] sd, input bit bp, input string tag);
        logic [7:0]    exp_ch[$];
        logic [7:0]    c;
        logic [NB-1:0] exp_word;
        int            exp_lat;
        int            n_eval;
        int            lat;
        int            hold;
        bit            exp_err;

        c        = (sd == 8'h00) ? 8'h01 : sd;
        exp_word = '0;
        exp_lat  = 0;
        exp_err  = (hang_bit >= 0);
        n_eval   = exp_err ? hang_bit + 1 : NB;
        for (int i = 0; i < n_eval; i++) begin
            exp_ch.push_back(c);
            c = lfsr_ref(c);
            if (i == hang_bit) exp_lat += SC + TO;
            else begin
                exp_lat += SC + w_cfg[i];
                exp_word[i] = r_cfg[i];
            end
        end

        cur_bit = 0;
        chall_obs.delete();
        start = 1'b1;
        seed  = sd;
        @(posedge clk);
        #1 start = 1'b0;
        seed = 8'($urandom);
        check({tag, " busy_after_start"}, 64'(busy), 64'd1);

        lat = 0;
        while (!resp_valid && lat < 1000) begin
            @(posedge clk);
            #1 lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " word"}, 64'(resp_word), 64'(exp_word));
        check({tag, " err"}, 64'(resp_err), 64'(exp_err));
        check({tag, " chall_count"}, 64'(chall_obs.size()), 64'(exp_ch.size()));
        for (int i = 0; i < exp_ch.size() && i < chall_obs.size(); i++)
            check($sformatf("%s chall%0d", tag, i), 64'(chall_obs[i]), 64'(exp_ch[i]));
        check({tag, " puf_en_done"}, 64'(puf_en), 64'd0);

        hold = bp ? 10 : $urandom_range(0, 3);
        for (int i = 0; i < hold; i++) begin
            start = bp && (i == 5);
            @(posedge clk);
            #1 start = 1'b0;
            check({tag, " hold_valid"}, 64'(resp_valid), 64'd1);
            check({tag, " hold_word"}, 64'(resp_word), 64'(exp_word));
        end
        resp_ready = 1'b1;
        start = bp;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        start = 1'b0;
        check({tag, " valid_drop"}, 64'(resp_valid), 64'd0);
        check({tag, " idle_busy"}, 64'(busy), 64'd0);
        check({tag, " word_held"}, 64'(resp_word), 64'(exp_word));
        if (bp) begin
            @(posedge clk);
            #1 check({tag, " start_ignored"}, 64'(busy), 64'd0);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 check("rst busy", 64'(busy), 64'd0);
        check("rst puf_en", 64'(puf_en), 64'd0);
        check("rst puf_rst", 64'(puf_rst), 64'd1);
        check("rst chall", 64'(puf_chall), 64'd0);
        check("rst word", 64'(resp_word), 64'd0);
        check("rst valid", 64'(resp_valid), 64'd0);
        check("rst err", 64'(resp_err), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Nominal: responses 1,0,1,1 after 3 RUN cycles each.
        for (int i = 0; i < NB; i++) w_cfg[i] = 3;
        r_cfg[0] = 1; r_cfg[1] = 0; r_cfg[2] = 1; r_cfg[3] = 1;
        do_txn(8'h01, 1'b0, "nominal");

        // Zero seed falls back to 0x01.
        randomize_cell();
        do_txn(8'h00, 1'b0, "zero_seed");

        randomize_cell();
        do_txn(8'($urandom), 1'b1, "backpressure");

        for (int t = 0; t < 5; t++) begin
            randomize_cell();
            do_txn(8'($urandom), 1'b0, $sformatf("rand%0d", t));
        end

        // Reset while bit 2 is being evaluated.
        randomize_cell();
        cur_bit = 0;
        start = 1'b1;
        seed  = 8'($urandom);
        @(posedge clk);
        #1 start = 1'b0;
        for (int t = 0; t < 200 && !(cur_bit == 2 && puf_en === 1'b1); t++) begin
            @(negedge clk);
            #1;
        end
        check("midrun reached", 64'(cur_bit == 2 && puf_en === 1'b1), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrun busy", 64'(busy), 64'd0);
        check("midrun word", 64'(resp_word), 64'd0);
        check("midrun puf_en", 64'(puf_en), 64'd0);
        check("midrun puf_rst", 64'(puf_rst), 64'd1);
        check("midrun valid", 64'(resp_valid), 64'd0);
        @(posedge clk);
        #1;
        randomize_cell();
        do_txn(8'($urandom), 1'b0, "after_rst");

`ifdef PUF_TIMEOUT_EN
        randomize_cell();
        hang_bit = 1;
        do_txn(8'($urandom), 1'b0, "timeout");
        hang_bit = -1;
        randomize_cell();
        do_txn(8'($urandom), 1'b0, "after_timeout");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
